// File: rtl/depp_byte_fifo.sv
// RX/TX byte buffering behind the DEPP byte port, FWFT registered heads, 1-cycle latency.
// Optional sticky overflow flags are built only when DEPP_FIFO_OVFL_EN is defined.

module depp_fifo_core #(
   parameter int LGFLEN = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push_req,
   input  logic [7:0]        push_data,
   input  logic              pop_req,
   output logic [7:0]        head,
   output logic              nonempty,
   output logic [LGFLEN:0]   fill,
   output logic              drop
);
   localparam int DEPTH = 1 << LGFLEN;
   localparam logic [LGFLEN:0]   FULL_CNT = (LGFLEN+1)'(DEPTH);
   localparam logic [LGFLEN:0]   F_ONE    = (LGFLEN+1)'(1);
   localparam logic [LGFLEN-1:0] P_ONE    = LGFLEN'(1);

   logic [7:0]        mem [0:DEPTH-1];
   logic [LGFLEN-1:0] wr_ptr, rd_ptr, rd_nxt;
   logic [LGFLEN:0]   fill_nxt;
   logic              push, pop;

   // A pop frees a slot in the same cycle, so a full FIFO can still take a push alongside it.
   assign pop  = pop_req && nonempty;
   assign push = push_req && ((fill != FULL_CNT) || pop);
   assign drop = push_req && !push;

   always_comb begin
      rd_nxt   = pop ? rd_ptr + P_ONE : rd_ptr;
      fill_nxt = fill;
      if (push && !pop)
         fill_nxt = fill + F_ONE;
      else if (pop && !push)
         fill_nxt = fill - F_ONE;
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fill     <= '0;
         nonempty <= 1'b0;
         head     <= 8'h00;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + P_ONE;
         rd_ptr   <= rd_nxt;
         fill     <= fill_nxt;
         nonempty <= (fill_nxt != '0);
         // The new head may be the byte being written right now, before it lands in mem.
         if (fill_nxt != '0)
            head <= (push && (rd_nxt == wr_ptr)) ? push_data : mem[rd_nxt];
      end
   end
endmodule

module depp_byte_fifo #(
   parameter int LGFLEN = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_rx_stb,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rd,
   output logic              o_rx_empty_n,
   output logic [7:0]        o_rx_data,
   output logic [LGFLEN:0]   o_rx_fill,
   input  logic              i_wr,
   input  logic [7:0]        i_wr_data,
   output logic              o_tx_full,
   output logic [LGFLEN:0]   o_tx_fill,
   output logic              o_tx_stb,
   output logic [7:0]        o_tx_data,
   input  logic              i_tx_busy,
   input  logic              i_clr_ovfl,
   output logic              o_rx_overflow,
   output logic              o_tx_overflow
);
   localparam logic [LGFLEN:0] FULL_CNT = (LGFLEN+1)'(1 << LGFLEN);

   logic rx_drop, tx_drop;

   depp_fifo_core #(.LGFLEN(LGFLEN)) u_rx (
      .clk       (i_clk),
      .reset     (i_reset),
      .push_req  (i_rx_stb),
      .push_data (i_rx_data),
      .pop_req   (i_rd),
      .head      (o_rx_data),
      .nonempty  (o_rx_empty_n),
      .fill      (o_rx_fill),
      .drop      (rx_drop)
   );

   // The port takes the head on any cycle it is not busy; the core ignores that when empty.
   depp_fifo_core #(.LGFLEN(LGFLEN)) u_tx (
      .clk       (i_clk),
      .reset     (i_reset),
      .push_req  (i_wr),
      .push_data (i_wr_data),
      .pop_req   (!i_tx_busy),
      .head      (o_tx_data),
      .nonempty  (o_tx_stb),
      .fill      (o_tx_fill),
      .drop      (tx_drop)
   );

   assign o_tx_full = (o_tx_fill == FULL_CNT);

`ifdef DEPP_FIFO_OVFL_EN
   // A drop in the same cycle as a clear leaves the flag set.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_rx_overflow <= 1'b0;
         o_tx_overflow <= 1'b0;
      end else begin
         if (rx_drop)
            o_rx_overflow <= 1'b1;
         else if (i_clr_ovfl)
            o_rx_overflow <= 1'b0;
         if (tx_drop)
            o_tx_overflow <= 1'b1;
         else if (i_clr_ovfl)
            o_tx_overflow <= 1'b0;
      end
   end
`else
   logic unused_ovfl;
   assign unused_ovfl   = i_clr_ovfl ^ rx_drop ^ tx_drop;
   assign o_rx_overflow = 1'b0;
   assign o_tx_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_depp_byte_fifo.sv
// Self-checking bench for depp_byte_fifo: directed scenarios plus random traffic against a queue model.
module tb_depp_byte_fifo;
   localparam int LGFLEN = 4;
   localparam int DEPTH  = 16;
`ifdef DEPP_FIFO_OVFL_EN
   localparam bit OVFL = 1'b1;
`else
   localparam bit OVFL = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset, rx_stb, rd, wr, tx_busy, clr_ovfl;
   logic [7:0] rx_data, wr_data;
   logic rx_empty_n, tx_full, tx_stb, rx_overflow, tx_overflow;
   logic [7:0] rx_head, tx_head;
   logic [LGFLEN:0] rx_fill, tx_fill;

   int checks = 0;
   int passed = 0;

   byte unsigned rxq[$];
   byte unsigned txq[$];
   bit m_rxo, m_txo;

   always #5 clk = ~clk;

   depp_byte_fifo #(.LGFLEN(LGFLEN)) dut (
      .i_clk(clk), .i_reset(reset),
      .i_rx_stb(rx_stb), .i_rx_data(rx_data), .i_rd(rd),
      .o_rx_empty_n(rx_empty_n), .o_rx_data(rx_head), .o_rx_fill(rx_fill),
      .i_wr(wr), .i_wr_data(wr_data), .o_tx_full(tx_full), .o_tx_fill(tx_fill),
      .o_tx_stb(tx_stb), .o_tx_data(tx_head), .i_tx_busy(tx_busy),
      .i_clr_ovfl(clr_ovfl), .o_rx_overflow(rx_overflow), .o_tx_overflow(tx_overflow)
   );

   // Reference: each FIFO is a queue; a pop happens first so a full queue can accept a push.
   task automatic cycle();
      bit rpop, rpush, tpop, tpush;
      if (reset) begin
         rxq.delete(); txq.delete(); m_rxo = 0; m_txo = 0;
      end else begin
         rpop  = rd && rxq.size() > 0;
         rpush = rx_stb && (rxq.size() < DEPTH || rpop);
         tpop  = !tx_busy && txq.size() > 0;
         tpush = wr && (txq.size() < DEPTH || tpop);
         if (rpop) void'(rxq.pop_front());
         if (rpush) rxq.push_back(rx_data);
         if (tpop) void'(txq.pop_front());
         if (tpush) txq.push_back(wr_data);
         if (OVFL) begin
            if (rx_stb && !rpush) m_rxo = 1; else if (clr_ovfl) m_rxo = 0;
            if (wr && !tpush)     m_txo = 1; else if (clr_ovfl) m_txo = 0;
         end
      end
      @(posedge clk); #1;
   endtask

   function automatic logic [30:0] model_vec();
      return {rxq.size() > 0, 5'(rxq.size()), (rxq.size() > 0) ? 8'(rxq[0]) : 8'h00,
              txq.size() > 0, txq.size() == DEPTH, 5'(txq.size()),
              (txq.size() > 0) ? 8'(txq[0]) : 8'h00, m_rxo, m_txo};
   endfunction

   function automatic logic [30:0] dut_vec();
      return {rx_empty_n, rx_fill, rx_empty_n ? rx_head : 8'h00,
              tx_stb, tx_full, tx_fill, tx_stb ? tx_head : 8'h00, rx_overflow, tx_overflow};
   endfunction

   task automatic idle_inputs();
      reset = 0; rx_stb = 0; rd = 0; wr = 0; tx_busy = 1; clr_ovfl = 0;
      rx_data = 0; wr_data = 0;
   endtask

   task automatic test_reset();
      idle_inputs(); reset = 1; cycle(); cycle(); reset = 0;
      checks++;
      if (dut_vec() !== 31'h0 || rx_head !== 8'h00 || tx_head !== 8'h00)
         $display("FAIL reset_state got %h rxd=%h txd=%h want 0", dut_vec(), rx_head, tx_head);
      else passed++;
   endtask

   task automatic test_rx_basic();
      rx_stb = 1; rx_data = 8'h41; cycle();
      checks++;
      if (rx_empty_n !== 1'b1 || rx_head !== 8'h41)
         $display("FAIL rx_first got ne=%b d=%h want 1/41", rx_empty_n, rx_head);
      else passed++;
      rx_data = 8'h42; cycle(); rx_stb = 0;
      rd = 1; cycle();
      checks++;
      if (rx_head !== 8'h42 || rx_fill !== 5'd1)
         $display("FAIL rx_second got d=%h fill=%0d want 42/1", rx_head, rx_fill);
      else passed++;
      cycle(); rd = 0;
      checks++;
      if (rx_empty_n !== 1'b0 || rx_fill !== 5'd0)
         $display("FAIL rx_drained got ne=%b fill=%0d want 0/0", rx_empty_n, rx_fill);
      else passed++;
   endtask

   task automatic test_rx_overflow();
      rx_stb = 1;
      for (int i = 0; i < DEPTH; i++) begin rx_data = 8'(i); cycle(); end
      rx_data = 8'h55; cycle(); rx_stb = 0;
      checks++;
      if (rx_fill !== 5'd16 || rx_overflow !== OVFL || rx_head !== 8'h00)
         $display("FAIL rx_overflow got fill=%0d ov=%b d=%h want 16/%b/00", rx_fill, rx_overflow, rx_head, OVFL);
      else passed++;
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (rx_head !== 8'(i) || rx_empty_n !== 1'b1)
            $display("FAIL rx_drain_order got %h want %h", rx_head, 8'(i));
         else passed++;
         rd = 1; cycle(); rd = 0;
      end
      clr_ovfl = 1; cycle(); clr_ovfl = 0;
      checks++;
      if (dut_vec() !== model_vec() || rx_overflow !== 1'b0)
         $display("FAIL rx_clear got %h want %h", dut_vec(), model_vec());
      else passed++;
   endtask

   task automatic test_rx_full_pushpop();
      rx_stb = 1;
      for (int i = 0; i < DEPTH; i++) begin rx_data = 8'($urandom); cycle(); end
      rd = 1; rx_data = 8'hAA; cycle(); rx_stb = 0; rd = 0;
      checks++;
      if (rx_fill !== 5'd16 || rx_overflow !== 1'b0 || dut_vec() !== model_vec())
         $display("FAIL rx_full_pushpop got fill=%0d ov=%b want 16/0", rx_fill, rx_overflow);
      else passed++;
      rd = 1;
      for (int i = 0; i < DEPTH - 1; i++) cycle();
      rd = 0;
      checks++;
      if (rx_head !== 8'hAA || rx_fill !== 5'd1)
         $display("FAIL rx_last_byte got %h fill=%0d want AA/1", rx_head, rx_fill);
      else passed++;
      rd = 1; cycle(); rd = 0;
   endtask

   task automatic test_tx_hold();
      int bad = 0;
      wr = 1; wr_data = 8'h10; cycle(); wr_data = 8'h11; cycle(); wr = 0;
      for (int i = 0; i < 20; i++) begin
         if (tx_stb !== 1'b1 || tx_head !== 8'h10) bad++;
         cycle();
      end
      checks++;
      if (bad != 0) $display("FAIL tx_hold got %0d bad cycles want 0", bad);
      else passed++;
      tx_busy = 0; cycle(); tx_busy = 1;
      checks++;
      if (tx_head !== 8'h11 || tx_stb !== 1'b1 || tx_fill !== 5'd1)
         $display("FAIL tx_accept got d=%h stb=%b fill=%0d want 11/1/1", tx_head, tx_stb, tx_fill);
      else passed++;
      tx_busy = 0; cycle(); cycle(); tx_busy = 1;
      checks++;
      if (tx_stb !== 1'b0 || tx_fill !== 5'd0)
         $display("FAIL tx_idle got stb=%b fill=%0d want 0/0", tx_stb, tx_fill);
      else passed++;
   endtask

   task automatic test_tx_overflow();
      wr = 1;
      for (int i = 0; i < DEPTH; i++) begin wr_data = 8'(8'h20 + i); cycle(); end
      checks++;
      if (tx_full !== 1'b1 || tx_overflow !== 1'b0)
         $display("FAIL tx_full got full=%b ov=%b want 1/0", tx_full, tx_overflow);
      else passed++;
      wr_data = 8'hEE; cycle(); wr = 0;
      checks++;
      if (tx_fill !== 5'd16 || tx_overflow !== OVFL || tx_head !== 8'h20)
         $display("FAIL tx_drop got fill=%0d ov=%b d=%h want 16/%b/20", tx_fill, tx_overflow, tx_head, OVFL);
      else passed++;
      // Push while full in the same cycle the port accepts: both must happen.
      wr = 1; wr_data = 8'h77; tx_busy = 0; clr_ovfl = 1; cycle(); wr = 0; tx_busy = 1; clr_ovfl = 0;
      checks++;
      if (dut_vec() !== model_vec() || tx_overflow !== 1'b0 || tx_head !== 8'h21)
         $display("FAIL tx_full_pushpop got %h want %h", dut_vec(), model_vec());
      else passed++;
      tx_busy = 0;
      for (int i = 0; i < DEPTH; i++) cycle();
      tx_busy = 1;
   endtask

   task automatic test_reset_mid();
      rx_stb = 1; wr = 1;
      for (int i = 0; i < DEPTH / 2; i++) begin rx_data = 8'($urandom); wr_data = 8'($urandom); cycle(); end
      rx_stb = 0; wr = 0;
      reset = 1; cycle(); reset = 0;
      checks++;
      if (rx_fill !== 5'd0 || tx_fill !== 5'd0 || rx_empty_n !== 1'b0 || tx_stb !== 1'b0)
         $display("FAIL reset_mid got rf=%0d tf=%0d ne=%b stb=%b want 0", rx_fill, tx_fill, rx_empty_n, tx_stb);
      else passed++;
   endtask

   task automatic test_random();
      int bad = 0;
      for (int i = 0; i < 3000; i++) begin
         reset    = ($urandom_range(0, 199) == 0);
         rx_stb   = ($urandom_range(0, 99) < 55);
         rd       = ($urandom_range(0, 99) < 45);
         wr       = ($urandom_range(0, 99) < 55);
         tx_busy  = ($urandom_range(0, 99) < 55);
         clr_ovfl = ($urandom_range(0, 19) == 0);
         rx_data  = 8'($urandom);
         wr_data  = 8'($urandom);
         cycle();
         checks++;
         if (dut_vec() !== model_vec()) begin
            bad++;
            if (bad < 10) $display("FAIL random_cycle%0d got %h want %h", i, dut_vec(), model_vec());
         end else passed++;
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_rx_basic();
      test_rx_overflow();
      test_rx_full_pushpop();
      test_tx_hold();
      test_tx_overflow();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
